// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register plus next-PC selection for the fetch stage.
//
// The next PC comes from one of: sequential increment, PC-relative branch, absolute jump,
// call (pushes the link value onto an internal return-address stack) or return (pops it).
// Only one action is taken per cycle, with priority rst > stall > ret > call > jmp > br.
//
// Ports:
//   clk_i           system clock, rising-edge active
//   rst_i           asynchronous active-high reset
//   stall_i         freeze PC, RAS and flags; redirect requests this cycle are dropped
//   br_taken_i      PC-relative branch request
//   br_offset_i     signed byte offset added to the current PC
//   jmp_i           absolute jump request
//   call_i          call request: push pc+STEP, go to jmp_target_i
//   ret_i           return request: pop the RAS top into the PC
//   jmp_target_i    absolute target for jmp and call
//   pc_o            current PC (registered)
//   pc_plus_step_o  pc_o + STEP (link value), combinational
//   ras_empty_o     RAS holds no entries
//   ras_full_o      RAS holds RAS_DEPTH entries
//   ras_ovf_o       sticky: call while RAS full (oldest entry overwritten)
//   ras_undf_o      sticky: ret while RAS empty

module pc_sequencer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] br_offset_i,
  input  logic             jmp_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_step_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_ovf_o,
  output logic             ras_undf_o
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    ActHold,
    ActInc,
    ActBr,
    ActJmp,
    ActCall,
    ActRet
  } action_e;

  action_e act;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;   // next free slot; top entry is ptr_q - 1
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             undf_q, undf_d;
  logic             push_en;
  logic [PtrW-1:0]  ptr_dec;
  logic [WIDTH-1:0] pc_plus_step;

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  assign pc_plus_step = pc_q + WIDTH'(STEP);
  assign ptr_dec      = ptr_q - PtrW'(1);

  // Priority decode of the requested action.
  always_comb begin
    act = ActInc;
    if (stall_i) begin
      act = ActHold;
    end else if (ret_i) begin
      act = ActRet;
    end else if (call_i) begin
      act = ActCall;
    end else if (jmp_i) begin
      act = ActJmp;
    end else if (br_taken_i) begin
      act = ActBr;
    end
  end

  // Next-state for PC, RAS pointer/count and sticky flags.
  always_comb begin
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    undf_d  = undf_q;
    push_en = 1'b0;
    unique case (act)
      ActHold: ;
      ActInc:  pc_d = pc_plus_step;
      ActBr:   pc_d = pc_q + br_offset_i;
      ActJmp:  pc_d = jmp_target_i;
      ActCall: begin
        // Pointer always advances, so a full stack wraps and overwrites its oldest entry.
        push_en = 1'b1;
        ptr_d   = ptr_q + PtrW'(1);
        pc_d    = jmp_target_i;
        if (cnt_q == CntFull) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ActRet: begin
        if (cnt_q != '0) begin
          pc_d  = ras_q[ptr_dec];
          ptr_d = ptr_dec;
          cnt_d = cnt_q - CntW'(1);
        end else begin
          pc_d   = pc_plus_step;
          undf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q   <= RESET_PC;
      ptr_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      undf_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      undf_q <= undf_d;
    end
  end

  // Stack contents need no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_en && !rst_i) begin
      ras_q[ptr_q] <= pc_plus_step;
    end
  end

  assign pc_o           = pc_q;
  assign pc_plus_step_o = pc_plus_step;
  assign ras_empty_o    = (cnt_q == '0);
  assign ras_full_o     = (cnt_q == CntFull);
  assign ras_ovf_o      = ovf_q;
  assign ras_undf_o     = undf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_offset;
  logic        jmp;
  logic        call;
  logic        ret;
  logic [31:0] jmp_target;
  logic [31:0] pc;
  logic [31:0] pc_plus_step;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_ovf;
  logic        ras_undf;

  int n_checks = 0;
  int n_errors = 0;

  pc_sequencer #(
    .WIDTH    (32),
    .STEP     (4),
    .RESET_PC (32'h0),
    .RAS_DEPTH(8)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .br_taken_i    (br_taken),
    .br_offset_i   (br_offset),
    .jmp_i         (jmp),
    .call_i        (call),
    .ret_i         (ret),
    .jmp_target_i  (jmp_target),
    .pc_o          (pc),
    .pc_plus_step_o(pc_plus_step),
    .ras_empty_o   (ras_empty),
    .ras_full_o    (ras_full),
    .ras_ovf_o     (ras_ovf),
    .ras_undf_o    (ras_undf)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; br_taken = 0; jmp = 0; call = 0; ret = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    rst = 0; br_offset = 0; jmp_target = 0;
    idle();

    // Reset with the clock stopped.
    #2 rst = 1;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_empty", ras_empty, 1);
    check("rst_full", ras_full, 0);
    check("rst_ovf", ras_ovf, 0);
    check("rst_undf", ras_undf, 0);
    #2 rst = 0;
    #2 clk_en = 1;

    for (int i = 1; i <= 3; i++) begin
      step();
      check("inc", pc, 32'(4 * i));
    end
    step();
    check("inc_10", pc, 32'h10);

    // Stalled branch requests are dropped.
    stall = 1; br_taken = 1; br_offset = -32'sd8;
    step(); check("stall1", pc, 32'h10);
    step(); check("stall2", pc, 32'h10);
    stall = 0;
    step(); check("branch_neg", pc, 32'h8);
    br_taken = 0;

    // Wrap-around.
    jmp = 1; jmp_target = 32'hFFFF_FFFC;
    step(); check("jmp_top", pc, 32'hFFFF_FFFC);
    jmp = 0;
    step(); check("wrap_pc", pc, 32'h0);
    check("wrap_ovf", ras_ovf, 0);
    check("wrap_undf", ras_undf, 0);

    // Call / return.
    jmp = 1; jmp_target = 32'h20;
    step(); jmp = 0;
    check("pc_20", pc, 32'h20);
    call = 1; jmp_target = 32'h100;
    step(); call = 0;
    check("call_pc", pc, 32'h100);
    check("call_empty", ras_empty, 0);
    check("call_pps", pc_plus_step, 32'h104);
    ret = 1;
    step(); ret = 0;
    check("ret_pc", pc, 32'h24);
    check("ret_empty", ras_empty, 1);

    // Overflow: links are 0x28 then 0x1000*(k-1)+4 for call k>=2.
    for (int k = 1; k <= 9; k++) begin
      call = 1; jmp_target = 32'(32'h1000 * k);
      step();
      if (k == 8) begin
        check("full_after8", ras_full, 1);
        check("no_ovf_after8", ras_ovf, 0);
      end
    end
    call = 0;
    check("ovf_after9", ras_ovf, 1);
    check("full_after9", ras_full, 1);
    check("pc_after9", pc, 32'h9000);
    ret = 1;
    for (int k = 9; k >= 2; k--) begin
      step();
      exp_pc = 32'(32'h1000 * (k - 1) + 4);
      check("pop_lifo", pc, exp_pc);
    end
    ret = 0;
    check("pop_empty", ras_empty, 1);

    // Underflow.
    ret = 1;
    step(); ret = 0;
    check("undf_pc", pc, 32'h1008);
    check("undf_flag", ras_undf, 1);

    // Priority: ret beats call and jmp, and the call does not push.
    call = 1; jmp_target = 32'h300;
    step(); call = 0;
    check("pre_prio_pc", pc, 32'h300);
    call = 1; ret = 1; jmp = 1; jmp_target = 32'h500;
    step(); idle();
    check("prio_pc", pc, 32'h100C);
    check("prio_empty", ras_empty, 1);
    check("prio_ovf_sticky", ras_ovf, 1);

    // Asynchronous reset mid-sequence discards RAS and flags.
    call = 1; jmp_target = 32'h400;
    step(); call = 0;
    check("pre_rst_empty", ras_empty, 0);
    #2 rst = 1;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_ovf", ras_ovf, 0);
    check("async_rst_undf", ras_undf, 0);
    check("async_rst_empty", ras_empty, 1);
    #1 rst = 0;
    step(); check("post_rst_pc", pc, 32'h4);
    ret = 1;
    step(); ret = 0;
    check("post_rst_ret_pc", pc, 32'h8);
    check("post_rst_undf", ras_undf, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the RISC datapath, the next generation of the fixed PC+4 adder. It holds the PC register and selects the next PC from sequential increment, PC-relative branch, absolute jump, call and return. Calls and returns go through an internal return-address stack (RAS) of configurable depth. It sits at the head of the fetch stage, drives the instruction-memory address, and takes redirect requests from the branch/control unit.

## Interface
- WIDTH, 32: PC and address width in bits.
- STEP, 4: sequential increment in bytes.
- RESET_PC, 0: PC value loaded on reset.
- RAS_DEPTH, 8: return-address stack entries (power of two, ≥2).
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hold PC and RAS; all redirect inputs ignored this cycle.
- br_taken  in  1  PC-relative branch request.
- br_offset  in  WIDTH  signed two's-complement byte offset, added to the current PC.
- jmp  in  1  absolute jump request.
- call  in  1  call request: push PC+STEP, go to jmp_target.
- ret  in  1  return request: pop RAS top into PC.
- jmp_target  in  WIDTH  absolute target for jmp and call.
- pc  out  WIDTH  current PC (registered).
- pc_plus_step  out  WIDTH  combinational pc+STEP (link value for the register file).
- ras_empty  out  1  RAS holds 0 entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.
- ras_ovf  out  1  sticky: a call happened while the RAS was full.
- ras_undf  out  1  sticky: a ret happened while the RAS was empty.

## Operation
- Only one action is taken per cycle. Priority: rst > stall > ret > call > jmp > br_taken > increment.
- Increment: pc ← pc+STEP.
- Branch: pc ← pc+br_offset.
- Jump: pc ← jmp_target.
- Call: RAS[top] ← pc+STEP, count+1; pc ← jmp_target.
- Ret with count>0: pc ← RAS top entry, count−1.
- Ret with count=0: pc ← pc+STEP, ras_undf ← 1, RAS unchanged.
- Call with count=RAS_DEPTH:
  - RAS works as a circular buffer; the oldest entry is overwritten.
  - count stays at RAS_DEPTH.
  - ras_ovf ← 1.
  - Jump to jmp_target still occurs.
- Arithmetic is modulo 2^WIDTH; wrap-around is silent (0xFFFFFFFC+4 = 0 for WIDTH=32).
- Targets are used unmodified; no alignment masking.
- Stall freezes pc, RAS contents, count and sticky flags. Requests asserted during stall are dropped, not queued.
- Sticky flags clear only on rst.

## Timing
- On rst assertion, outputs update immediately without waiting for clk:
  - pc = RESET_PC.
  - RAS count = 0, so ras_empty=1 and ras_full=0.
  - ras_ovf = 0, ras_undf = 0.
  - RAS contents are don't-care.
- Deassertion of rst is synchronous to the design; the first update happens on the first rising clk edge with rst low.
- Latency: inputs are sampled on a rising edge, and the new pc is visible after that same edge (1 cycle).
- pc_plus_step follows pc combinationally within the same cycle.
- ras_empty and ras_full are decoded from the registered count and change with pc.
- Call and ret in the same cycle: ret wins, no push; the call is lost.
- rst asserted mid-sequence (for example between call and ret) discards all RAS state.

## Test plan
- Reset and increment:
  - Stimulus: assert rst with clk stopped.
  - Required: pc=0 immediately.
  - Stimulus: release rst, run 3 edges.
  - Required: pc = 4, 8, 0xC.
- Stall and branch:
  - Stimulus: at pc=0x10, stall=1 with br_taken=1 for 2 cycles.
  - Required: pc stays 0x10.
  - Stimulus: stall=0, br_taken=1, br_offset=−8.
  - Required: pc=0x8.
- Wrap-around:
  - Stimulus: jmp to 0xFFFFFFFC, then one increment.
  - Required: pc=0x00000000, no flags set.
- Call/return:
  - Stimulus: at pc=0x20, call with jmp_target=0x100.
  - Required: pc=0x100, ras_empty=0, pc_plus_step=0x104.
  - Stimulus: ret.
  - Required: pc=0x24, ras_empty=1.
- Overflow:
  - Stimulus: 9 consecutive calls with RAS_DEPTH=8.
  - Required: ras_full=1 after the 8th call; ras_ovf=1 after the 9th.
  - Stimulus: 8 rets.
  - Required: pops return the 2nd…9th link values in LIFO order; the 1st link value is lost.
- Underflow and priority:
  - Stimulus: ret on an empty RAS.
  - Required: pc+=4, ras_undf=1.
  - Stimulus: call+ret+jmp in the same cycle with a non-empty RAS.
  - Required: ret taken, no push.
  - Stimulus: rst pulse.
  - Required: both sticky flags clear.
